// File: rtl/serial_tx_port.sv
// Memory-mapped 8N1 UART transmitter: bus writes fill a small TX FIFO that a
// bit-timing FSM drains onto tx_out; STATUS/CTRL registers are readable.
module serial_tx_port #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset_in,
    input  logic        bus_cs,
    input  logic [3:0]  bus_addr,
    input  logic        bus_wren,
    input  logic        bus_rden,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_wmask,
    output logic [31:0] bus_rdata,
    output logic        tx_out,
    output logic        tx_busy,
    output logic        irq_empty
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned BAUD_W = 16;
    localparam int unsigned BIT_W  = 3;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic              irq_en_q, irq_en_d;
    logic              irq_q, irq_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [7:0]        mem_q [FIFO_DEPTH];

    logic wr_txdata, wr_ctrl, rd_req, fifo_empty, fifo_full, push, pop;
    logic unused_bits;

    assign wr_txdata  = bus_cs && bus_wren && (bus_addr == 4'h0) && bus_wmask[0];
    assign wr_ctrl    = bus_cs && bus_wren && (bus_addr == 4'h8) && bus_wmask[0];
    assign rd_req     = bus_cs && bus_rden;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q >= DEPTH_C);
    assign push       = wr_txdata && !fifo_full;
    assign unused_bits = ^{bus_wdata[31:8], bus_wmask[3:1]};

    // State register
    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus_wdata[7:0];
        end
    end

    // Next-state: serialiser, FIFO bookkeeping and register file
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        pop      = 1'b0;
        ovf_d    = ovf_q;
        irq_en_d = irq_en_q;
        rdata_d  = rdata_q;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = ST_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    baud_d  = '0;
                end
            end
            ST_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                // Stop bit; chain straight into the next frame when data is waiting
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
        endcase

        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (rd_req) begin
            case (bus_addr)
                4'h4:    rdata_d = {24'h0, count_q[3:0], ovf_q, fifo_empty, fifo_full, busy_q};
                4'h8:    rdata_d = {31'h0, irq_en_q};
                default: rdata_d = '0;
            endcase
        end

        // A dropped write on the same edge as a STATUS read keeps overflow set
        if (rd_req && (bus_addr == 4'h4)) begin
            ovf_d = 1'b0;
        end
        if (wr_txdata && fifo_full) begin
            ovf_d = 1'b1;
        end

        if (wr_ctrl) begin
            irq_en_d = bus_wdata[0];
        end

        irq_d = irq_en_d && (count_d == '0) && !busy_d;
    end

    assign bus_rdata = rdata_q;
    assign tx_out    = tx_q;
    assign tx_busy   = busy_q;
    assign irq_empty = irq_q;

endmodule

// File: tb/tb_serial_tx_port.sv
// Self-checking bench for serial_tx_port: directed vector table, hand-written
// frame/reset sequences and random bus traffic against a frame-level model.
module tb_serial_tx_port;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int          FRAME = 10 * CPB;

    logic        clock = 1'b0;
    logic        reset_in = 1'b1;
    logic        bus_cs = 1'b0;
    logic [3:0]  bus_addr = 4'h0;
    logic        bus_wren = 1'b0;
    logic        bus_rden = 1'b0;
    logic [31:0] bus_wdata = 32'h0;
    logic [3:0]  bus_wmask = 4'h0;
    logic [31:0] bus_rdata;
    logic        tx_out;
    logic        tx_busy;
    logic        irq_empty;

    serial_tx_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset_in  (reset_in),
        .bus_cs    (bus_cs),
        .bus_addr  (bus_addr),
        .bus_wren  (bus_wren),
        .bus_rden  (bus_rden),
        .bus_wdata (bus_wdata),
        .bus_wmask (bus_wmask),
        .bus_rdata (bus_rdata),
        .tx_out    (tx_out),
        .tx_busy   (tx_busy),
        .irq_empty (irq_empty)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Frame-level reference model: queue of bytes plus time within current frame
    logic [7:0]  mq[$];
    logic        m_active;
    int          m_t;
    logic [7:0]  m_cur;
    logic        m_ovf;
    logic        m_irq_en;
    logic [31:0] m_rdata;

    typedef struct {
        logic        cs;
        logic        wr;
        logic        rd;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          gap;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_active = 1'b0;
        m_t      = 0;
        m_cur    = 8'h0;
        m_ovf    = 1'b0;
        m_irq_en = 1'b0;
        m_rdata  = 32'h0;
    endtask

    function automatic logic m_line();
        int b;
        if (!m_active) return 1'b1;
        b = m_t / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        return 1'b1;
    endfunction

    // Advance the model by one clock edge using the inputs presented at that edge
    task automatic model_edge();
        int         cnt;
        logic       ovf_ev;
        logic [3:0] c4;
        cnt    = mq.size();
        ovf_ev = 1'b0;
        c4     = 4'(cnt);
        if (bus_cs && bus_rden) begin
            case (bus_addr)
                4'h4:    m_rdata = {24'h0, c4, m_ovf, cnt == 0, cnt >= DEPTH, m_active};
                4'h8:    m_rdata = {31'h0, m_irq_en};
                default: m_rdata = 32'h0;
            endcase
        end
        if (!m_active) begin
            if (cnt > 0) begin
                m_cur = mq.pop_front();
                m_active = 1'b1;
                m_t = 0;
            end
        end else if (m_t == FRAME - 1) begin
            if (cnt > 0) begin
                m_cur = mq.pop_front();
                m_t = 0;
            end else begin
                m_active = 1'b0;
            end
        end else begin
            m_t++;
        end
        if (bus_cs && bus_wren && bus_wmask[0]) begin
            if (bus_addr == 4'h0) begin
                if (cnt < DEPTH) mq.push_back(bus_wdata[7:0]);
                else ovf_ev = 1'b1;
            end else if (bus_addr == 4'h8) begin
                m_irq_en = bus_wdata[0];
            end
        end
        if (bus_cs && bus_rden && bus_addr == 4'h4) m_ovf = 1'b0;
        if (ovf_ev) m_ovf = 1'b1;
    endtask

    task automatic check_outputs();
        check("tx_out", 32'(tx_out), 32'(m_line()));
        check("tx_busy", 32'(tx_busy), 32'(m_active));
        check("irq_empty", 32'(irq_empty), 32'(m_irq_en && mq.size() == 0 && !m_active));
        check("bus_rdata", bus_rdata, m_rdata);
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic cs, input logic wr, input logic rd, input logic [3:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wmask);
        bus_cs    = cs;
        bus_wren  = wr;
        bus_rden  = rd;
        bus_addr  = addr;
        bus_wdata = wdata;
        bus_wmask = wmask;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    endtask

    initial begin
        //                cs    wr    rd    addr  wdata          mask  gap  chk   exp
        tbl.push_back('{1'b1, 1'b0, 1'b1, 4'h4, 32'h0,         4'h0, 0,   1'b1, 32'h4});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 32'h55,        4'h1, 45,  1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 32'h41,        4'h1, 0,   1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 32'h42,        4'h1, 0,   1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 32'h43,        4'h1, 0,   1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 4'h4, 32'h0,         4'h0, 130, 1'b1, 32'h21});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 32'h10,        4'h1, 0,   1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 32'hA0,        4'h1, 0,   1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 32'hA1,        4'h1, 0,   1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 32'hA2,        4'h1, 0,   1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 32'hA3,        4'h1, 0,   1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 32'hA4,        4'h1, 0,   1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 4'h4, 32'h0,         4'h0, 0,   1'b1, 32'h4B});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 4'h4, 32'h0,         4'h0, 220, 1'b1, 32'h43});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 32'h77,        4'h0, 0,   1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 4'h4, 32'h0,         4'h0, 0,   1'b1, 32'h4});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h4, 32'hFF,        4'hF, 0,   1'b0, 32'h0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'h0, 32'h66,        4'h1, 0,   1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 4'h4, 32'h0,         4'h0, 0,   1'b1, 32'h4});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h8, 32'h1,         4'h1, 0,   1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 4'h8, 32'h0,         4'h0, 0,   1'b1, 32'h1});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 4'h0, 32'h0,         4'h0, 0,   1'b1, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 4'h8, 32'h0,         4'h0, 0,   1'b1, 32'h1});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 4'hC, 32'hDEADBEEF,  4'hF, 0,   1'b1, 32'h0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 32'h5A,        4'h1, 50,  1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 4'h8, 32'h0,         4'h0, 0,   1'b1, 32'h1});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 4'h4, 32'h0,         4'h0, 0,   1'b1, 32'h1});

        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("rst_tx_out", 32'(tx_out), 32'h1);
        check("rst_tx_busy", 32'(tx_busy), 32'h0);
        check("rst_irq", 32'(irq_empty), 32'h0);
        check("rst_rdata", bus_rdata, 32'h0);
        reset_in = 1'b0;
        repeat (20) cyc();

        foreach (tbl[i]) begin
            drive(tbl[i].cs, tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].wmask);
            cyc();
            if (tbl[i].chk) check($sformatf("tbl[%0d]_rdata", i), bus_rdata, tbl[i].exp);
            idle();
            repeat (tbl[i].gap) cyc();
        end

        // 0x55 frame timing with the bit pattern written out directly
        repeat (5) cyc();
        drive(1'b1, 1'b1, 1'b0, 4'h0, 32'h55, 4'h1);
        cyc();
        idle();
        for (int k = 0; k < FRAME; k++) begin
            logic want;
            cyc();
            if (k < CPB) want = 1'b0;
            else if (k >= 9 * CPB) want = 1'b1;
            else want = (((k - CPB) / CPB) % 2 == 0);
            check($sformatf("frame55_bit_k%0d", k), 32'(tx_out), 32'(want));
            check("frame55_busy", 32'(tx_busy), 32'h1);
        end
        cyc();
        check("frame55_busy_fall", 32'(tx_busy), 32'h0);
        check("frame55_irq_back", 32'(irq_empty), 32'h1);

        // Asynchronous reset during data bit 3 of a frame with another byte queued
        repeat (3) cyc();
        drive(1'b1, 1'b1, 1'b0, 4'h0, 32'hF0, 4'h1);
        cyc();
        drive(1'b1, 1'b1, 1'b0, 4'h0, 32'h33, 4'h1);
        cyc();
        idle();
        repeat (17) cyc();
        check("pre_rst_line_low", 32'(tx_out), 32'h0);
        #2;
        reset_in = 1'b1;
        #1;
        check("async_rst_tx_out", 32'(tx_out), 32'h1);
        check("async_rst_busy", 32'(tx_busy), 32'h0);
        check("async_rst_irq", 32'(irq_empty), 32'h0);
        check("async_rst_rdata", bus_rdata, 32'h0);
        model_reset();
        @(posedge clock);
        #1;
        reset_in = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 4'h4, 32'h0, 4'h0);
        cyc();
        check("post_rst_status", bus_rdata, 32'h4);
        idle();
        repeat (60) cyc();

        // Random bus traffic against the model
        for (int n = 0; n < 1500; n++) begin
            logic [1:0] sel;
            sel = 2'($urandom_range(0, 3));
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0,
                  {sel, 2'b00}, $urandom, 4'($urandom));
            cyc();
        end
        idle();
        repeat (10) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
